// File: rtl/bus_dma_master_if.sv
// Word-bus signal bundle shared by a bus initiator and its slaves.
// Strobes and the grant/ready handshake are active-low.
interface bus_dma_master_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic              req_;
  logic              grnt_;
  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rdy_;

  modport master (
    output req_, as_, rw, addr, wr_data,
    input  grnt_, rd_data, rdy_
  );

  modport slave (
    input  req_, as_, rw, addr, wr_data,
    output grnt_, rd_data, rdy_
  );
endinterface

// File: rtl/bus_dma_master.sv
// Word-bus DMA initiator: copies LEN words, one read then one write per word,
// holding the bus from grant until completion or rdy_ timeout.
module bus_dma_master #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned TMO_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  bus_dma_master_if.master  bus
);

  // Last waiting count before abort: the counter would hit all-ones on this cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_FIN,
    S_ABT
  } state_e;

  state_e            state_q,   state_d;
  logic [ADDR_W-1:0] cur_src_q, cur_src_d;
  logic [ADDR_W-1:0] cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0]  rem_q,     rem_d;
  logic [TMO_W-1:0]  tmo_q,     tmo_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic              req_n_q,   req_n_d;
  logic              as_n_q,    as_n_d;
  logic              rw_q,      rw_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [ADDR_W-1:0] src_nxt_c;
  logic [ADDR_W-1:0] dst_nxt_c;

  assign src_nxt_c = cur_src_q + ADDR_W'(1);
  assign dst_nxt_c = cur_dst_q + ADDR_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    rem_d     = rem_q;
    tmo_d     = tmo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    req_n_d   = req_n_q;
    as_n_d    = as_n_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            cur_src_d = src_addr;
            cur_dst_d = dst_addr;
            rem_d     = len;
            req_n_d   = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (!bus.grnt_) begin
          as_n_d  = 1'b0;
          rw_d    = 1'b1;
          addr_d  = cur_src_q;
          tmo_d   = '0;
          state_d = S_RD;
        end
      end

      S_RD, S_WR: begin
        if (!bus.rdy_) begin
          tmo_d = '0;
          if (state_q == S_RD) begin
            // Strobe stays low into the write; only address and direction change.
            wr_data_d = bus.rd_data;
            as_n_d    = 1'b0;
            rw_d      = 1'b0;
            addr_d    = cur_dst_q;
            state_d   = S_WR;
          end else begin
            rem_d     = rem_q - LEN_W'(1);
            cur_src_d = src_nxt_c;
            cur_dst_d = dst_nxt_c;
            if (rem_q == LEN_W'(1)) begin
              as_n_d  = 1'b1;
              rw_d    = 1'b1;
              state_d = S_FIN;
            end else begin
              as_n_d  = 1'b0;
              rw_d    = 1'b1;
              addr_d  = src_nxt_c;
              state_d = S_RD;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          as_n_d  = 1'b1;
          rw_d    = 1'b1;
          state_d = S_ABT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_FIN: begin
        req_n_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_ABT: begin
        req_n_d = 1'b1;
        busy_d  = 1'b0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      rem_q     <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      req_n_q   <= 1'b1;
      as_n_q    <= 1'b1;
      rw_q      <= 1'b1;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      rem_q     <= rem_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      req_n_q   <= req_n_d;
      as_n_q    <= as_n_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign bus.req_    = req_n_q;
  assign bus.as_     = as_n_q;
  assign bus.rw      = rw_q;
  assign bus.addr    = addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: 1-cycle register slave, parked/delayed grant,
// expected-access queue checked on every completed access plus directed literals.
module tb_bus_dma_master;

  typedef struct packed {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] data;
  } acc_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [29:0] src;
  logic [29:0] dst;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;

  bus_dma_master_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  bus_dma_master #(.ADDR_W(30), .DATA_W(32), .LEN_W(16), .TMO_W(8)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .src_addr (src),
    .dst_addr (dst),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave memory: unwritten words read back as a fixed address pattern.
  logic [31:0] mem [bit [29:0]];

  function automatic logic [31:0] src_pat(input logic [29:0] a);
    if (a >= 30'h100 && a < 30'h104) return 32'hA0 + 32'(a - 30'h100);
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return src_pat(a);
  endfunction

  // 1-cycle slave: acks the cycle after it sees as_ low, then releases rdy_.
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int stall_wr = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdy_ <= 1'b1;
    end else if (!bus.rdy_) begin
      bus.rdy_ <= 1'b1;
    end else if (!bus.as_) begin
      if (bus.rw) begin
        bus.rd_data <= mem_rd(bus.addr);
        rd_cnt = rd_cnt + 1;
        bus.rdy_ <= 1'b0;
      end else if (wr_cnt + 1 != stall_wr) begin
        mem[bus.addr] = bus.wr_data;
        wr_cnt = wr_cnt + 1;
        bus.rdy_ <= 1'b0;
      end
    end
  end

  // Expected access stream and per-cycle checks.
  acc_t        exp_q[$];
  acc_t        e;
  logic        acc_en     = 1'b1;
  logic [29:0] watch_addr = 30'h3FFF_FFF0;
  int done_cnt = 0, err_cnt = 0, req_cyc = 0, as_cyc = 0, busy_cyc = 0, watch_cyc = 0;

  always @(negedge clk) begin
    chk("req_vs_busy", bus.req_, !busy);
    chk("done_err_excl", done & err, 1'b0);
    if (!bus.as_) chk("as_implies_busy", busy, 1'b1);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (!bus.req_) req_cyc++;
    if (!bus.as_) as_cyc++;
    if (busy) busy_cyc++;
    if (!bus.as_ && !bus.rw && bus.addr == watch_addr) watch_cyc++;
    if (acc_en && !bus.as_ && !bus.rdy_) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_access_addr", bus.addr, 30'h3FFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("acc_rw", bus.rw, e.rw);
        chk("acc_addr", bus.addr, e.addr);
        if (!e.rw) chk("acc_wr_data", bus.wr_data, e.data);
      end
    end
  end

  task automatic plan_copy(input logic [29:0] s, input logic [29:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [29:0] sa;
      logic [29:0] da;
      sa = s + 30'(i);
      da = d + 30'(i);
      exp_q.push_back({1'b1, sa, 32'h0});
      exp_q.push_back({1'b0, da, mem_rd(sa)});
    end
  endtask

  task automatic do_start(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n);
    @(negedge clk);
    src = s; dst = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges from the one after the start edge until done or err.
  task automatic wait_end(input int budget, output int cyc_n);
    cyc_n = 1;
    while (!(done || err)) begin
      if (cyc_n >= budget) begin
        chk("end_timeout", cyc_n, 0);
        break;
      end
      @(negedge clk);
      cyc_n++;
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  int c, rd0, wr0, dn0, er0, rq0, as0, bz0, wt0;

  task automatic snap();
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
    rq0 = req_cyc; as0 = as_cyc; bz0 = busy_cyc; wt0 = watch_cyc;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    bus.grnt_ = 1'b0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req_", bus.req_, 1'b1);
    chk("rst_as_", bus.as_, 1'b1);
    chk("rst_rw", bus.rw, 1'b1);
    chk("rst_addr", bus.addr, 30'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    settle();

    // Basic 4-word copy with parked grant.
    snap();
    plan_copy(30'h100, 30'h200, 4);
    do_start(30'h100, 30'h200, 16'd4);
    wait_end(200, c);
    chk("copy4_done_latency", c, 19);
    settle();
    chk("copy4_reads", rd_cnt - rd0, 4);
    chk("copy4_writes", wr_cnt - wr0, 4);
    chk("copy4_done_pulses", done_cnt - dn0, 1);
    chk("copy4_busy_cycles", busy_cyc - bz0, 18);
    chk("copy4_queue_left", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) chk("copy4_mem", mem_rd(30'h200 + 30'(i)), 32'hA0 + 32'(i));

    // Zero length: done only, no bus activity.
    snap();
    do_start(30'h100, 30'h280, 16'd0);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b0);
    @(negedge clk);
    chk("len0_done_drop", done, 1'b0);
    settle();
    chk("len0_req_cycles", req_cyc - rq0, 0);
    chk("len0_as_cycles", as_cyc - as0, 0);
    chk("len0_done_pulses", done_cnt - dn0, 1);

    // Grant withheld for 10 cycles.
    snap();
    bus.grnt_ = 1'b1;
    plan_copy(30'h140, 30'h240, 2);
    do_start(30'h140, 30'h240, 16'd2);
    for (int i = 0; i < 10; i++) begin
      chk("gdly_req_low", bus.req_, 1'b0);
      chk("gdly_as_high", bus.as_, 1'b1);
      @(negedge clk);
    end
    bus.grnt_ = 1'b0;
    wait_end(300, c);
    settle();
    chk("gdly_queue_left", exp_q.size(), 0);
    chk("gdly_done_pulses", done_cnt - dn0, 1);
    chk("gdly_mem0", mem_rd(30'h240), 32'h5A5A_0140);
    chk("gdly_mem1", mem_rd(30'h241), 32'h5A5A_0141);

    // Slave withholds rdy_ on the second write.
    snap();
    stall_wr   = wr_cnt + 2;
    watch_addr = 30'h2A1;
    exp_q.push_back({1'b1, 30'h180, 32'h0});
    exp_q.push_back({1'b0, 30'h2A0, 32'h5A5A_0180});
    exp_q.push_back({1'b1, 30'h181, 32'h0});
    do_start(30'h180, 30'h2A0, 16'd2);
    wait_end(1000, c);
    chk("tmo_err_seen", err, 1'b1);
    settle();
    chk("tmo_stall_cycles", watch_cyc - wt0, 255);
    chk("tmo_err_pulses", err_cnt - er0, 1);
    chk("tmo_done_pulses", done_cnt - dn0, 0);
    chk("tmo_writes", wr_cnt - wr0, 1);
    chk("tmo_mem0", mem_rd(30'h2A0), 32'h5A5A_0180);
    chk("tmo_mem1_unwritten", mem.exists(30'h2A1), 1'b0);
    chk("tmo_queue_left", exp_q.size(), 0);
    chk("tmo_req_released", bus.req_, 1'b1);
    stall_wr   = 0;
    watch_addr = 30'h3FFF_FFF0;

    // Source address wrap.
    snap();
    plan_copy(30'h3FFF_FFFF, 30'h300, 2);
    do_start(30'h3FFF_FFFF, 30'h300, 16'd2);
    wait_end(200, c);
    settle();
    chk("wrap_queue_left", exp_q.size(), 0);
    chk("wrap_mem0", mem_rd(30'h300), 32'h65A5_FFFF);
    chk("wrap_mem1", mem_rd(30'h301), 32'h5A5A_0000);

    // Start while busy is ignored.
    snap();
    plan_copy(30'h400, 30'h500, 3);
    do_start(30'h400, 30'h500, 16'd3);
    repeat (3) @(negedge clk);
    src = 30'h600; dst = 30'h700; len = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(200, c);
    settle();
    chk("busy_start_queue_left", exp_q.size(), 0);
    chk("busy_start_done", done_cnt - dn0, 1);
    chk("busy_start_reads", rd_cnt - rd0, 3);
    chk("busy_start_writes", wr_cnt - wr0, 3);
    chk("busy_start_no_dst2", mem.exists(30'h700), 1'b0);

    // Asynchronous reset during a read.
    acc_en = 1'b0;
    snap();
    do_start(30'h420, 30'h520, 16'd4);
    c = 0;
    while (!(!bus.as_ && bus.rw) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rst_mid_reached_rd", bus.as_, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_as_", bus.as_, 1'b1);
    chk("rst_mid_req_", bus.req_, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_addr", bus.addr, 30'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    settle();
    chk("rst_mid_no_done", done_cnt - dn0, 0);
    chk("rst_mid_no_err", err_cnt - er0, 0);
    chk("rst_mid_idle", busy, 1'b0);
    acc_en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_dma_master.md
Name: bus_dma_master

Overview:
- Bus initiator (master) for the on-chip word bus, the opposite end of the cs_/as_/rw/addr/wr_data/rd_data/rdy_ slave protocol used by peripherals such as the timer.
- Copies LEN words from a source word address to a destination word address.
- Each word is one bus read followed by one bus write. The bus is requested once per transfer and held until the transfer finishes.
- Sits beside the CPU as a second bus master. Commands arrive from a local control block.

Parameters:
- ADDR_W, 30, word-address width (matches WordAddrBus).
- DATA_W, 32, data width (matches WordDataBus).
- LEN_W, 16, transfer-length counter width.
- TMO_W, 8, width of the per-access rdy_ timeout counter. Timeout occurs at 2^TMO_W-1 cycles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- start  in  1  one-cycle command strobe
- src_addr  in  ADDR_W  source word address, sampled on start
- dst_addr  in  ADDR_W  destination word address, sampled on start
- len  in  LEN_W  number of words, sampled on start
- busy  out  1  high from the cycle after an accepted start until done or err
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on timeout abort
- req_  out  1  bus request, active-low
- grnt_  in  1  bus grant, active-low
- as_  out  1  address strobe, active-low
- rw  out  1  1 = read, 0 = write
- addr  out  ADDR_W  bus word address
- wr_data  out  DATA_W  write data
- rd_data  in  DATA_W  read data, valid when rdy_ is low
- rdy_  in  1  slave ready, active-low

Behaviour:
- Reset values:
  - busy, done, err = 0.
  - req_ = 1, as_ = 1, rw = 1.
  - addr = 0, wr_data = 0.
  - Internal counters = 0. State = IDLE.
- All outputs are registered.
- States: IDLE, REQ, RD, WR, FIN, ABT.
- IDLE:
  - On start with len≠0: latch src, dst, len into cur_src, cur_dst, remaining. Drive req_ = 0 and busy = 1. Go to REQ.
  - On start with len = 0: pulse done next cycle. No bus activity. busy stays 0.
- REQ: wait for grnt_ = 0. On grant, drive as_ = 0, rw = 1, addr = cur_src, clear the timeout counter, go to RD. There is no timeout in REQ.
- RD:
  - Hold as_, rw and addr stable until rdy_ is sampled low.
  - On that edge: capture rd_data into a holding register and drive wr_data from it. Set as_ = 0, rw = 0, addr = cur_dst. Go to WR.
  - as_ stays low across the RD→WR boundary, with changed address and rw. Slaves decode on every edge.
- WR: on rdy_ = 0, decrement remaining, increment cur_src and cur_dst (mod 2^ADDR_W, wrap silently).
  - If remaining was 1: set as_ = 1, rw = 1, go to FIN.
  - Otherwise: set as_ = 0, rw = 1, addr = next src, go to RD.
- FIN: set req_ = 1, busy = 0, done = 1 for one cycle. Return to IDLE.
- Timeout:
  - In RD and WR, the counter increments each cycle that rdy_ = 1 and clears on each new access.
  - At all-ones: as_ = 1, rw = 1, go to ABT.
  - ABT: req_ = 1, busy = 0, err pulse. Return to IDLE.
  - A word whose write was aborted is not counted.
- Loss of grant: grnt_ going high during RD or WR is a protocol violation. The block ignores it and completes the access.
- A start while busy is ignored. Parameters are not re-latched.
- A slave may see the access strobe for one extra edge after it asserts rdy_, because as_ deasserts one cycle after rdy_ is sampled. Accesses must therefore be idempotent; this holds for all register slaves.
- Throughput: with a 1-cycle slave (rdy_ one cycle after as_), one word takes 4 cycles: 2 for the read, 2 for the write.
- Reset mid-transfer: all outputs return to reset values immediately and asynchronously. No done or err pulse is issued.

Test Plan:
- src=0x100, dst=0x200, len=4, immediate grant, 1-cycle slave holding 0xA0..0xA3: memory 0x200..0x203 = 0xA0..0xA3. Exactly 4 reads and 4 writes. done pulses once. busy high ~16 cycles.
- len=0: done pulses one cycle after start. req_ and as_ never assert. busy stays 0.
- Grant delayed 10 cycles: req_ low throughout the delay, as_ stays high until grnt_=0. Then copies correctly.
- Slave withholds rdy_ on the 2nd write: after 255 cycles as_ and req_ go high and err pulses. The 1st word is written, the 2nd is not. done never pulses.
- src=0x3FFFFFFF, len=2: the second read is to address 0x0 (wrap).
- Second start while busy with different addresses: ignored, original transfer completes unchanged. Reset asserted mid-RD: as_=1, req_=1, busy=0 immediately.
